// File: rtl/cache_fill_if.sv
// cache_fill_if: cache-miss, memory-read and array-write signals of one
// cache_fill_fsm instance. The slave modport is the controller's view; the
// master modport is the view of the cache/memory side that drives it.
// Optional feature macro: CACHE_FILL_ERR_CHECK_EN adds the sticky fill_error.
interface cache_fill_if;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] write_word_addr;
    logic        write_tag_array;
`ifdef CACHE_FILL_ERR_CHECK_EN
    logic        fill_error;

    modport slave (
        input  miss_detected, miss_address, memory_data_valid,
        output fsm_busy, memory_read, memory_address,
        output write_data_array, write_word_addr, write_tag_array, fill_error
    );
    modport master (
        output miss_detected, miss_address, memory_data_valid,
        input  fsm_busy, memory_read, memory_address,
        input  write_data_array, write_word_addr, write_tag_array, fill_error
    );
`else
    modport slave (
        input  miss_detected, miss_address, memory_data_valid,
        output fsm_busy, memory_read, memory_address,
        output write_data_array, write_word_addr, write_tag_array
    );
    modport master (
        output miss_detected, miss_address, memory_data_valid,
        input  fsm_busy, memory_read, memory_address,
        input  write_data_array, write_word_addr, write_tag_array
    );
`endif
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: line-fill controller for one L1 cache. On a miss it issues
// WORDS back-to-back word reads to pipelined memory, writes each returning
// beat into the data array in order, and writes the tag with the last beat.
// Issued and received words are counted separately, so any memory latency
// and any gaps between beats are tolerated.
// Optional feature macro: CACHE_FILL_ERR_CHECK_EN (sticky fill_error on a
// beat that has no outstanding request).
module cache_fill_fsm #(
    parameter int WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    cache_fill_if.slave bus
);
    localparam int              CW        = $clog2(WORDS) + 1;
    localparam logic [CW-1:0]   WORDS_C   = CW'(WORDS);
    localparam logic [CW-1:0]   LAST_C    = CW'(WORDS - 1);
    localparam logic [CW-1:0]   ONE_C     = CW'(1);
    localparam logic [CW-1:0]   ZERO_C    = CW'(0);
    localparam logic [15:0]     LINE_MASK = 16'(2 * WORDS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_base;
    logic [15:0]   w_base_nxt;
    logic [CW-1:0] r_issue_cnt;
    logic [CW-1:0] w_issue_nxt;
    logic [CW-1:0] r_rx_cnt;
    logic [CW-1:0] w_rx_nxt;

    logic          w_busy;
    logic          w_read;
    logic [15:0]   w_maddr;
    logic          w_wr;
    logic [15:0]   w_waddr;
    logic          w_tag;

    // Word counts converted to byte offsets within the line (16-bit words).
    logic [15:0]   w_issue_ofs;
    logic [15:0]   w_rx_ofs;
    assign w_issue_ofs = {{(15 - CW){1'b0}}, r_issue_cnt, 1'b0};
    assign w_rx_ofs    = {{(15 - CW){1'b0}}, r_rx_cnt, 1'b0};

    // State, line base and the two word counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= 16'h0000;
            r_issue_cnt <= ZERO_C;
            r_rx_cnt    <= ZERO_C;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_issue_cnt <= w_issue_nxt;
            r_rx_cnt    <= w_rx_nxt;
        end
    end

    // Next state, request issue and beat acceptance; strobes see only the beat input.
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_issue_nxt = r_issue_cnt;
        w_rx_nxt    = r_rx_cnt;
        w_busy      = 1'b0;
        w_read      = 1'b0;
        w_maddr     = 16'h0000;
        w_wr        = 1'b0;
        w_waddr     = 16'h0000;
        w_tag       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.miss_detected) begin
                    w_state_nxt = S_FILL;
                    w_base_nxt  = bus.miss_address & ~LINE_MASK;
                    w_issue_nxt = ZERO_C;
                    w_rx_nxt    = ZERO_C;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FILL: begin
                w_busy = 1'b1;
                if (r_issue_cnt < WORDS_C) begin
                    w_read      = 1'b1;
                    w_maddr     = r_base + w_issue_ofs;
                    w_issue_nxt = r_issue_cnt + ONE_C;
                end else begin
                    w_issue_nxt = r_issue_cnt;
                end
                // Only beats with an outstanding request are written.
                if (bus.memory_data_valid && (r_rx_cnt < r_issue_cnt)) begin
                    w_wr     = 1'b1;
                    w_waddr  = r_base + w_rx_ofs;
                    w_rx_nxt = r_rx_cnt + ONE_C;
                    if (r_rx_cnt == LAST_C) begin
                        w_tag       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_FILL;
                    end
                end else begin
                    w_rx_nxt = r_rx_cnt;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.fsm_busy         = w_busy;
    assign bus.memory_read      = w_read;
    assign bus.memory_address   = w_maddr;
    assign bus.write_data_array = w_wr;
    assign bus.write_word_addr  = w_waddr;
    assign bus.write_tag_array  = w_tag;

`ifdef CACHE_FILL_ERR_CHECK_EN
    logic r_fill_error;

    // Sticky flag for a beat arriving with no outstanding request, in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_error <= 1'b0;
        end else if (bus.memory_data_valid && (r_rx_cnt == r_issue_cnt)) begin
            r_fill_error <= 1'b1;
        end else begin
            r_fill_error <= r_fill_error;
        end
    end

    assign bus.fill_error = r_fill_error;
`endif
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized bench for cache_fill_fsm. A memory responder
// returns one beat per request after MEM_LAT cycles (optionally with random
// gaps); a transaction-level model predicts every output each cycle.
// Build with CACHE_FILL_ERR_CHECK_EN defined to also check fill_error.
module tb_cache_fill_fsm;
    localparam int WORDS   = 8;
    localparam int MEM_LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_fill_if ifc();

    cache_fill_fsm #(.WORDS(WORDS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int   cyc = 0;
    int   req_q[$];
    int   gap_left = 0;
    bit   gap_en = 1'b0;
    logic mem_beat = 1'b0;
    logic stray = 1'b0;

    assign ifc.memory_data_valid = mem_beat | stray;

    always @(negedge clk) begin
        if (rst_n && ifc.memory_read) req_q.push_back(cyc);
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        mem_beat = 1'b0;
        if (req_q.size() > 0 && req_q[0] + MEM_LAT <= cyc) begin
            if (gap_left > 0) begin
                gap_left--;
            end else begin
                mem_beat = 1'b1;
                void'(req_q.pop_front());
                gap_left = gap_en ? int'($urandom_range(0, 3)) : 0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    bit          m_busy = 1'b0;
    int          m_cyc = 0;     // 1-based cycle within the current fill
    int          m_rx = 0;      // beats accepted in this fill
    bit          m_err = 1'b0;
    logic [15:0] m_wq[$];       // line word addresses still to be written
    int          m_base = 0;

    // DUT-observed statistics of the most recent fill
    int          s_len = 0, s_reads = 0, s_writes = 0, s_tags = 0;
    int          s_tag_cyc = 0, s_first_wr = 0;
    logic [15:0] s_first_req = 16'h0, s_last_req = 16'h0, s_last_wr = 16'h0;
    int          idle_run = 0, last_idle = 0;
    int          tot_writes = 0, tot_tags = 0;
    bit          prev_busy = 1'b0;

    always @(negedge clk) begin
        logic        e_busy, e_read, e_wr, e_tag, e_err;
        logic [15:0] e_maddr, e_waddr;
        int          issued;
        bit          acc;
        acc = 1'b0;
        if (!rst_n) begin
            e_busy = 1'b0; e_read = 1'b0; e_wr = 1'b0; e_tag = 1'b0; e_err = 1'b0;
            e_maddr = 16'h0; e_waddr = 16'h0;
            m_busy = 1'b0; m_err = 1'b0; m_wq.delete();
        end else begin
            issued  = (m_cyc - 1 < WORDS) ? m_cyc - 1 : WORDS;
            e_busy  = m_busy;
            e_read  = m_busy && (m_cyc <= WORDS);
            e_maddr = e_read ? 16'(m_base + 2 * (m_cyc - 1)) : 16'h0;
            acc     = m_busy && ifc.memory_data_valid && (m_rx < issued);
            e_wr    = acc;
            e_waddr = acc ? m_wq[0] : 16'h0;
            e_tag   = acc && (m_wq.size() == 1);
            e_err   = m_err;
        end
        chk("fsm_busy",         16'(ifc.fsm_busy),         16'(e_busy));
        chk("memory_read",      16'(ifc.memory_read),      16'(e_read));
        chk("memory_address",   ifc.memory_address,        e_maddr);
        chk("write_data_array", 16'(ifc.write_data_array), 16'(e_wr));
        chk("write_word_addr",  ifc.write_word_addr,       e_waddr);
        chk("write_tag_array",  16'(ifc.write_tag_array),  16'(e_tag));
`ifdef CACHE_FILL_ERR_CHECK_EN
        chk("fill_error",       16'(ifc.fill_error),       16'(e_err));
`endif
        if (rst_n) begin
            if (ifc.memory_data_valid && !acc) m_err = 1'b1;
            if (!m_busy) begin
                if (ifc.miss_detected) begin
                    m_busy = 1'b1;
                    m_cyc  = 1;
                    m_rx   = 0;
                    m_base = int'(ifc.miss_address) & ~(2 * WORDS - 1) & 32'hFFFF;
                    m_wq.delete();
                    for (int k = 0; k < WORDS; k++) m_wq.push_back(16'(m_base + 2 * k));
                end
            end else begin
                if (acc) begin
                    void'(m_wq.pop_front());
                    m_rx++;
                    if (m_wq.size() == 0) m_busy = 1'b0;
                end
                m_cyc++;
            end
            if (ifc.fsm_busy && !prev_busy) begin
                last_idle = idle_run;
                s_len = 0; s_reads = 0; s_writes = 0; s_tags = 0; s_tag_cyc = 0; s_first_wr = 0;
            end
            if (ifc.fsm_busy) begin s_len++; idle_run = 0; end
            else idle_run++;
            if (ifc.memory_read) begin
                if (s_reads == 0) s_first_req = ifc.memory_address;
                s_last_req = ifc.memory_address;
                s_reads++;
            end
            if (ifc.write_data_array) begin
                if (s_writes == 0) s_first_wr = s_len;
                s_last_wr = ifc.write_word_addr;
                s_writes++;
                tot_writes++;
            end
            if (ifc.write_tag_array) begin
                s_tags++;
                s_tag_cyc = s_len;
                tot_tags++;
            end
            prev_busy = ifc.fsm_busy;
        end else begin
            prev_busy = 1'b0;
            idle_run  = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!ifc.fsm_busy) return;
            step();
        end
        n_checks++;
        n_err++;
        $display("FAIL wait_idle: fsm_busy still 1 after %0d cycles", budget);
    endtask

    task automatic do_miss(input logic [15:0] addr);
        ifc.miss_address  = addr;
        ifc.miss_detected = 1'b1;
        step();
        ifc.miss_detected = 1'b0;
        ifc.miss_address  = 16'($urandom);
    endtask

    int tags0, writes0;

    initial begin
        ifc.miss_detected = 1'b0;
        ifc.miss_address  = 16'h0000;
        rst_n = 1'b0;
        repeat (3) step();
        chk("reset busy", 16'(ifc.fsm_busy), 16'h0);
        chk("reset read", 16'(ifc.memory_read), 16'h0);
        rst_n = 1'b1;
        repeat (2) step();

        // basic fill at 0x1234, fixed latency
        do_miss(16'h1234);
        wait_idle(40);
        chk("t1 busy cycles", 16'(s_len),      16'd12);
        chk("t1 first req",   s_first_req,     16'h1230);
        chk("t1 last req",    s_last_req,      16'h123E);
        chk("t1 reads",       16'(s_reads),    16'd8);
        chk("t1 writes",      16'(s_writes),   16'd8);
        chk("t1 first wr cyc",16'(s_first_wr), 16'd5);
        chk("t1 last wr",     s_last_wr,       16'h123E);
        chk("t1 tag cyc",     16'(s_tag_cyc),  16'd12);
        chk("t1 tags",        16'(s_tags),     16'd1);
        repeat (2) step();

        // top-of-memory line
        do_miss(16'hFFFF);
        wait_idle(40);
        chk("t2 first req", s_first_req,   16'hFFF0);
        chk("t2 last req",  s_last_req,    16'hFFFE);
        chk("t2 last wr",   s_last_wr,     16'hFFFE);
        chk("t2 tags",      16'(s_tags),   16'd1);
        repeat (2) step();

        // random beat gaps, random addresses
        gap_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            do_miss(16'($urandom));
            wait_idle(80);
            chk("t3 tags",    16'(s_tags),   16'd1);
            chk("t3 writes",  16'(s_writes), 16'd8);
            chk("t3 tag last",16'(s_tag_cyc), 16'(s_len));
            repeat ($urandom_range(0, 3)) step();
        end
        gap_en = 1'b0;
        repeat (6) step();

        // miss held high with a changing address
        ifc.miss_address  = 16'h2468;
        ifc.miss_detected = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            ifc.miss_address = 16'($urandom);
            step();
            if (!ifc.fsm_busy) break;
        end
        ifc.miss_address = 16'($urandom);
        step();
        ifc.miss_address = 16'($urandom);
        step();
        chk("t4 refill busy", 16'(ifc.fsm_busy), 16'h1);
        chk("t4 idle gap",    16'(last_idle),    16'd1);
        ifc.miss_detected = 1'b0;
        wait_idle(40);
        repeat (8) step();

        // reset in cycle 6 of a fill
        tags0   = tot_tags;
        writes0 = tot_writes;
        do_miss(16'h4000);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("t5 rst busy",  16'(ifc.fsm_busy),         16'h0);
        chk("t5 rst read",  16'(ifc.memory_read),      16'h0);
        chk("t5 rst addr",  ifc.memory_address,        16'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        stray = 1'b1;
        step();
        stray = 1'b0;
        repeat (10) step();
        chk("t5 no tag",    16'(tot_tags - tags0),     16'd0);
        chk("t5 writes",    16'(tot_writes - writes0), 16'd1);

        // stray beat in IDLE after a clean reset, then a normal fill
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        stray = 1'b1;
        step();
        stray = 1'b0;
        step();
`ifdef CACHE_FILL_ERR_CHECK_EN
        chk("t6 err set",  16'(ifc.fill_error), 16'h1);
`endif
        do_miss(16'h8A5C);
        wait_idle(40);
        chk("t6 tags", 16'(s_tags), 16'd1);
`ifdef CACHE_FILL_ERR_CHECK_EN
        chk("t6 err sticky", 16'(ifc.fill_error), 16'h1);
`endif
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
